temp_sched: RTL and testbench
=============================

# temp_sched

Time-multiplexed sampling scheduler and shared accumulator for up to N_CH sign-magnitude temperature sensors. It generates the one-second sampling tick and drives the external sensor mux select. It sweeps all channels through a single adder into per-channel sums. After each 2^WIN_LOG2-sweep window it emits one averaged result per channel over a valid/ready handshake. It sits between the sensor mux and the display/reporting logic, replacing one-channel-per-accumulator averaging.

## Interface
- CLK_PER_SEC, 50000000, clock cycles per sampling tick.
- N_CH, 4, number of sensor channels (2..16).
- WIN_LOG2, 6, log2 of sweeps per averaging window (1..8).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  run enable; low parks the block in IDLE.
- temperatura  in  9  sensor sample for the channel on `sel`. Bit 8 is the sign (1 = negative), bits 7:0 are the magnitude.
- sel  out  $clog2(N_CH)  external sensor mux select.
- sec_tick  out  1  one-cycle pulse per tick.
- win_cnt  out  WIN_LOG2  sweeps completed in the current window.
- avg_valid  out  1  average available.
- avg_ready  in  1  consumer accepts the average.
- avg_ch  out  $clog2(N_CH)  channel of the current average.
- avg_data  out  11  signed two's-complement average, sign-extended.
- win_done  out  1  one-cycle pulse after the last channel's average is accepted.
- overrun  out  1  sticky; a tick was dropped.

## Operation
- Reset (rst=0 at a clk edge):
  - Clears all state, sums, counters and `overrun`.
  - All outputs are 0; state is IDLE.
- Tick counter:
  - Counts 0..CLK_PER_SEC-1 while `en`=1.
  - `sec_tick`=1 on the cycle the counter equals CLK_PER_SEC-1, then the counter wraps to 0.
  - When `en`=0, the counter is held at 0.
- FSM states: IDLE, WAIT, SAMPLE, DUMP.
  - IDLE -> WAIT when `en`=1.
  - WAIT -> SAMPLE on `sec_tick` or a pending tick.
  - SAMPLE walks `sel` from 0 to N_CH-1, one channel per cycle:
    - `sum[sel]` += magnitude when bit 8 = 0.
    - `sum[sel]` -= magnitude when bit 8 = 1.
    - 9'h100 (negative zero) adds 0.
  - After channel N_CH-1, `win_cnt` increments.
    - If `win_cnt` wraps to 0 (window complete) -> DUMP with `avg_ch`=0.
    - Otherwise -> WAIT.
  - DUMP:
    - `avg_valid`=1, `avg_data` = `sum[avg_ch]` >>> WIN_LOG2 (arithmetic shift).
    - On `avg_valid` & `avg_ready`, `sum[avg_ch]` clears and `avg_ch` increments.
    - After channel N_CH-1 is accepted: `win_done` pulses, `avg_valid`=0, -> WAIT.
- Sum width is 8+WIN_LOG2+1 bits, signed; it never overflows. `avg_data` covers the range -255..255.
- Tick during SAMPLE or DUMP sets a one-deep pending flag, consumed on the next WAIT.
  - A tick while pending is already set is dropped: `overrun` <= 1 (sticky until reset) and `win_cnt` is unaffected.
- `en` falling: the current SAMPLE sweep or DUMP completes, then the FSM goes to IDLE.
  - Sums, `win_cnt` and pending are cleared on entry to IDLE.
  - `overrun` is kept.
- `sel` holds its last value outside SAMPLE. `avg_ch` and `avg_data` are 0 outside DUMP.

## Timing
- A tick at cycle T puts the FSM in SAMPLE at T+1; channel k is sampled (`sel`=k) at cycle T+1+k.
- `temperatura` is combinational from `sel` via the external mux and is captured at the same clk edge.
- The window's last sample at cycle T+N_CH is followed by DUMP with `avg_valid`=1 at T+N_CH+1.
- With `avg_ready` tied 1, one average is transferred per cycle. `win_done` asserts the cycle after the last transfer.
- While `avg_valid`=1 and `avg_ready`=0, `avg_ch` and `avg_data` are stable.
- Simultaneous tick and last DUMP handshake: the tick goes pending and SAMPLE starts 2 cycles later.

## Configuration
- TEMP_SCHED_ROUND_EN:
  - Defined: `avg_data` = (sum + 2^(WIN_LOG2-1)) >>> WIN_LOG2, i.e. round half toward +inf. The sum width grows by 1 bit.
  - Undefined: plain arithmetic shift, i.e. floor toward -inf.

## Test plan
Bench parameters: CLK_PER_SEC=4, N_CH=2, WIN_LOG2=2.
- Reset: rst=0 for 3 cycles mid-run -> all outputs 0 the cycle after the first rst=0 edge. The next window's averages exclude pre-reset samples.
- Constant inputs: ch0=+20 (9'h014), ch1=-10 (9'h10A), `avg_ready`=1 -> after 4 ticks, ch0 avg=11'h014 and ch1 avg=11'h7F6, then `win_done` pulses once.
- Rounding:
  - Inputs: ch0 samples 1,1,1,0; ch1 samples -1,0,0,0.
  - Without TEMP_SCHED_ROUND_EN: averages 0 and 11'h7FF.
  - With TEMP_SCHED_ROUND_EN: averages 1 and 0.
- Negative zero: ch0=9'h100 for a whole window -> avg 0.
- Backpressure:
  - Hold `avg_ready`=0 for 5 cycles in DUMP -> data stable.
  - Hold it for 9 cycles (≥2 ticks) -> first tick pending, second sets `overrun`=1; the next window completes after 4 consumed ticks.
- Disable: `en`=0 mid-window -> the current sweep finishes, then IDLE with `win_cnt`=0. Re-enable -> averages cover only new samples.

Source files
------------

// File: rtl/temp_sched.sv
// temp_sched: one-second sampling scheduler with a shared accumulator for
// N_CH sign-magnitude temperature sensors. Each tick sweeps every channel
// through one adder into per-channel sums; after 2^WIN_LOG2 sweeps the
// per-channel averages are handed out over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active low
//   en           run enable (low parks the block in IDLE once a sweep/dump ends)
//   temperatura  sample for channel `sel`: bit 8 sign (1 = negative), 7:0 magnitude
//   sel          external sensor mux select
//   sec_tick     one-cycle pulse every CLK_PER_SEC cycles while en = 1
//   win_cnt      sweeps completed in the current window
//   avg_valid    average available (DUMP state)
//   avg_ready    consumer accepts the average
//   avg_ch       channel of the presented average (0 outside DUMP)
//   avg_data     signed two's-complement average, sign-extended (0 outside DUMP)
//   win_done     one-cycle pulse after the last channel's average is accepted
//   overrun      sticky: a tick arrived while one was already pending
//
// Build option: define TEMP_SCHED_ROUND_EN to round averages half toward
// +inf; otherwise the average is an arithmetic shift (floor).
//
// state  | meaning
// IDLE   | parked; sums, win_cnt and pending are clear
// WAIT   | waiting for a tick (or a pending one) to start a sweep
// SAMPLE | sweeping sel 0..N_CH-1, one channel per cycle
// DUMP   | presenting per-channel averages over avg_valid/avg_ready

module temp_sched #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int N_CH        = 4,
  parameter int WIN_LOG2    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [8:0]              temperatura,
  output logic [$clog2(N_CH)-1:0] sel,
  output logic                    sec_tick,
  output logic [WIN_LOG2-1:0]     win_cnt,
  output logic                    avg_valid,
  input  logic                    avg_ready,
  output logic [$clog2(N_CH)-1:0] avg_ch,
  output logic [10:0]             avg_data,
  output logic                    win_done,
  output logic                    overrun
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
`ifdef TEMP_SCHED_ROUND_EN
  localparam int SUM_W = WIN_LOG2 + 10;
`else
  localparam int SUM_W = WIN_LOG2 + 9;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DUMP   = 2'd3;

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [1:0]              state;
  logic [CNT_W-1:0]        tick_cnt;
  logic                    pending;
  logic signed [SUM_W-1:0] sums [N_CH];

  logic signed [SUM_W-1:0] mag;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] dump_sum;
  logic signed [SUM_W-1:0] dump_biased;
  logic signed [SUM_W-1:0] dump_shift;
  logic [SUM_W+10:0]       dump_ext;
  logic                    win_wrap;
  logic                    last_sample;
  logic                    last_accept;
  logic                    to_idle;

  // ---------------- tick counter ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (!en || tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign sec_tick = en && (tick_cnt == CNT_LAST);

  // ---------------- datapath ----------------
  always_comb begin
    mag   = {{(SUM_W-8){1'b0}}, temperatura[7:0]};
    // negative zero (9'h100) negates to zero, so it adds nothing
    delta = temperatura[8] ? -mag : mag;
  end

  always_comb begin
    dump_sum = sums[avg_ch];
`ifdef TEMP_SCHED_ROUND_EN
    dump_biased = dump_sum + SUM_W'(2 ** (WIN_LOG2 - 1));
`else
    dump_biased = dump_sum;
`endif
    dump_shift = dump_biased >>> WIN_LOG2;
    // shifted value lies in -255..255, so its low 11 bits are the result
    dump_ext   = {{11{dump_shift[SUM_W-1]}}, dump_shift};
    avg_data   = (state == S_DUMP) ? dump_ext[10:0] : 11'd0;
  end

  assign avg_valid = (state == S_DUMP);

  // ---------------- control ----------------
  assign win_wrap    = &win_cnt;
  assign last_sample = (state == S_SAMPLE) && (sel == LAST_CH);
  assign last_accept = (state == S_DUMP) && avg_ready && (avg_ch == LAST_CH);

  // leaving for IDLE only at sweep/dump boundaries; a completed window still dumps
  assign to_idle = !en && ((state == S_WAIT) ||
                           (last_sample && !win_wrap) ||
                           last_accept);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      sel      <= '0;
      win_cnt  <= '0;
      avg_ch   <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      win_done <= 1'b0;
      for (int i = 0; i < N_CH; i++) sums[i] <= '0;
    end else begin
      win_done <= 1'b0;

      if (sec_tick && (state == S_SAMPLE || state == S_DUMP)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (to_idle) begin
            state <= S_IDLE;
          end else if (sec_tick || pending) begin
            state   <= S_SAMPLE;
            sel     <= '0;
            // a fresh tick coinciding with a consumed pending one stays pending
            pending <= sec_tick && pending;
          end
        end
        S_SAMPLE: begin
          sums[sel] <= sums[sel] + delta;
          if (sel == LAST_CH) begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (win_wrap) begin
              state  <= S_DUMP;
              avg_ch <= '0;
            end else if (to_idle) begin
              state <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            sel <= sel + SEL_W'(1);
          end
        end
        S_DUMP: begin
          if (avg_ready) begin
            sums[avg_ch] <= '0;
            if (avg_ch == LAST_CH) begin
              win_done <= 1'b1;
              avg_ch   <= '0;
              state    <= to_idle ? S_IDLE : S_WAIT;
            end else begin
              avg_ch <= avg_ch + SEL_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (to_idle) begin
        win_cnt <= '0;
        pending <= 1'b0;
        for (int i = 0; i < N_CH; i++) sums[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_temp_sched.sv
module tb_temp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        avg_ready;
  logic [8:0]  temperatura;
  logic        sel;
  logic        sec_tick;
  logic [1:0]  win_cnt;
  logic        avg_valid;
  logic        avg_ch;
  logic [10:0] avg_data;
  logic        win_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;

  logic [8:0]  pat0 [4];
  logic [8:0]  pat1 [4];
  logic [11:0] sb [$];

`ifdef TEMP_SCHED_ROUND_EN
  localparam logic [10:0] E_RND0 = 11'h001;
  localparam logic [10:0] E_RND1 = 11'h000;
  localparam logic [10:0] E_MIX1 = 11'h002;
`else
  localparam logic [10:0] E_RND0 = 11'h000;
  localparam logic [10:0] E_RND1 = 11'h7FF;
  localparam logic [10:0] E_MIX1 = 11'h001;
`endif

  temp_sched #(.CLK_PER_SEC(4), .N_CH(2), .WIN_LOG2(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .temperatura (temperatura),
    .sel         (sel),
    .sec_tick    (sec_tick),
    .win_cnt     (win_cnt),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .avg_ch      (avg_ch),
    .avg_data    (avg_data),
    .win_done    (win_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external mux: sweep k of a window samples pattern entry k
  assign temperatura = (sel == 1'b0) ? pat0[win_cnt] : pat1[win_cnt];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pats(input logic [8:0] a0, a1, a2, a3, b0, b1, b2, b3);
    pat0[0] = a0; pat0[1] = a1; pat0[2] = a2; pat0[3] = a3;
    pat1[0] = b0; pat1[1] = b1; pat1[2] = b2; pat1[3] = b3;
  endtask

  task automatic push_exp(input logic [10:0] e0, input logic [10:0] e1);
    sb.push_back({1'b0, e0});
    sb.push_back({1'b1, e1});
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (win_done) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL win_done_timeout: got none expected pulse within 200 cycles");
    end
  endtask

  task automatic wait_valid();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (avg_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("avg_valid_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic run_window(input logic [10:0] e0, input logic [10:0] e1);
    int t;
    push_exp(e0, e1);
    en = 1'b1;
    wait_done(t);
    en = 1'b0;
    @(negedge clk);
  endtask

  // scoreboard monitor: compares every accepted average
  always @(negedge clk) begin
    #1;
    if (rst && avg_valid && avg_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL avg_unexpected: got ch %0d data %0h expected no transfer", avg_ch, avg_data);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        check("avg_transfer", {20'd0, avg_ch, avg_data}, {20'd0, e});
      end
    end
    if (rst && win_done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int ta;
    int tb2;
    logic found;
    rst = 1'b0;
    en = 1'b0;
    avg_ready = 1'b1;
    set_pats(9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000);
    repeat (3) @(negedge clk);
    check("reset_outputs", {13'd0, sel, sec_tick, win_cnt, avg_valid, avg_ch, avg_data, win_done, overrun}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // rounding: ch0 sums to 3, ch1 to -1
    set_pats(9'h001, 9'h001, 9'h001, 9'h000, 9'h101, 9'h000, 9'h000, 9'h000);
    run_window(E_RND0, E_RND1);

    // negative zero and full-scale negative
    set_pats(9'h100, 9'h100, 9'h100, 9'h100, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    run_window(11'h000, 11'h701);

    // full-scale positive and mixed signs (+5 -3 +7 -2 = 7)
    set_pats(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h005, 9'h103, 9'h007, 9'h102);
    run_window(11'h0FF, E_MIX1);
    check("overrun_clear", {31'd0, overrun}, 32'd0);

    // backpressure for 5 cycles: presented average must hold
    set_pats(9'h014, 9'h014, 9'h014, 9'h014, 9'h10A, 9'h10A, 9'h10A, 9'h10A);
    avg_ready = 1'b0;
    push_exp(11'h014, 11'h7F6);
    en = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp5_hold", {19'd0, avg_valid, avg_ch, avg_data}, {19'd0, 1'b1, 1'b0, 11'h014});
      @(negedge clk);
    end
    avg_ready = 1'b1;
    wait_done(ta);
    en = 1'b0;
    @(negedge clk);

    // reset mid-run: pre-reset samples must not leak into the next window
    set_pats(9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064);
    en = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_midrun", {13'd0, sel, sec_tick, win_cnt, avg_valid, avg_ch, avg_data, win_done, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    set_pats(9'h014, 9'h014, 9'h014, 9'h014, 9'h10A, 9'h10A, 9'h10A, 9'h10A);
    push_exp(11'h014, 11'h7F6);
    rst = 1'b1;
    wait_done(ta);
    en = 1'b0;
    @(negedge clk);

    // backpressure for 9 cycles: overrun, then a full 4-sweep window
    set_pats(9'h080, 9'h080, 9'h080, 9'h080, 9'h1C8, 9'h1C8, 9'h1C8, 9'h1C8);
    avg_ready = 1'b0;
    push_exp(11'h080, 11'h738);
    push_exp(11'h080, 11'h738);
    en = 1'b1;
    wait_valid();
    for (int i = 0; i < 9; i++) begin
      check("bp9_hold", {19'd0, avg_valid, avg_ch, avg_data}, {19'd0, 1'b1, 1'b0, 11'h080});
      @(negedge clk);
    end
    avg_ready = 1'b1;
    wait_done(ta);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_done(tb2);
    check("bp9_window_gap", tb2 - ta, 32'd15);
    en = 1'b0;
    @(negedge clk);

    // disable mid-window: second sweep finishes, then IDLE with win_cnt = 0
    set_pats(9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064, 9'h064);
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sel == 1'b0 && win_cnt == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("dis_sweep_start", {31'd0, found}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("dis_sweep_finish", {29'd0, sel, win_cnt}, {29'd0, 1'b1, 2'd1});
    @(negedge clk);
    check("dis_idle", {29'd0, win_cnt, avg_valid}, 32'd0);
    check("overrun_kept", {31'd0, overrun}, 32'd1);
    set_pats(9'h032, 9'h032, 9'h032, 9'h032, 9'h132, 9'h132, 9'h132, 9'h132);
    run_window(11'h032, 11'h7CE);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("win_done_count", n_done, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
